// File: rtl/pmem_types_pkg.sv
// Shared types and geometry for the burst-responder memory model.
// No logic, no latency.
// No flow control.
package pmem_types_pkg;

    localparam int unsigned BEATS    = 4;
    localparam int unsigned BEAT_W   = 64;
    localparam int unsigned LINE_W   = 256;
    localparam int unsigned OFFSET_W = 5;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } pmem_state_e;

    // Extract 64-bit beat k from a 256-bit line (beat 0 is the low word).
    function automatic logic [BEAT_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        k);
        return line[k*BEAT_W +: BEAT_W];
    endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Line storage: 2^S_INDEX lines of 256 bits, one async read port, one full-line write port.
// Read is combinational; a write lands on the next rising edge.
// No flow control; synchronous clear wipes every line.
module pmem_line_array
    import pmem_types_pkg::*;
#(
    parameter int unsigned S_INDEX = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_INDEX-1:0] rd_idx,
    output logic [LINE_W-1:0]  rd_line,
    input  logic               wr_en,
    input  logic [S_INDEX-1:0] wr_idx,
    input  logic [LINE_W-1:0]  wr_line
);

    localparam int unsigned NLINES = 1 << S_INDEX;

    logic [LINE_W-1:0] mem_q [NLINES];
    logic [LINE_W-1:0] mem_d [NLINES];

    // Next array contents: only the addressed line changes, and only on commit.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_idx] = wr_line;
        end
    end

    // Line storage with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NLINES; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_line = mem_q[rd_idx];

endmodule

// File: rtl/pmem_burst_responder.sv
// Physical-memory model answering 4-beat read/write line bursts after DELAY idle cycles.
// Latency: request accepted -> first pmem_resp beat DELAY+1 cycles later, then 4 beats.
// Initiator holds the request to the last beat; a dropped request aborts the burst.
module pmem_burst_responder
    import pmem_types_pkg::*;
#(
    parameter int unsigned DELAY   = 10,
    parameter int unsigned S_INDEX = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [31:0]       pmem_address,
    input  logic [BEAT_W-1:0] pmem_wdata,
    output logic [BEAT_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              pmem_error
);

    pmem_state_e       state_q, state_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic [1:0]        beat_q,  beat_d;
    logic              is_wr_q, is_wr_d;
    logic [S_INDEX-1:0] idx_q,  idx_d;
    logic [LINE_W-1:0] stage_q, stage_d;
    logic              resp_q,  resp_d;
    logic [BEAT_W-1:0] rdata_q, rdata_d;
    logic              err_q,   err_d;

    logic              req_held;
    logic              req_other;
    logic              wr_en;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rd_line;

    // Only the line-index field of the address matters; offset and high bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pmem_address[31:OFFSET_W+S_INDEX], pmem_address[OFFSET_W-1:0]};

    pmem_line_array #(
        .S_INDEX (S_INDEX)
    ) u_lines (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_q),
        .rd_line (rd_line),
        .wr_en   (wr_en),
        .wr_idx  (idx_q),
        .wr_line (wr_line)
    );

    // Next-state logic: accept, count down, stream beats, commit writes, wait for release.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        beat_d    = beat_q;
        is_wr_d   = is_wr_q;
        idx_d     = idx_q;
        stage_d   = stage_q;
        resp_d    = 1'b0;
        rdata_d   = '0;
        err_d     = err_q;
        wr_en     = 1'b0;
        wr_line   = stage_q;
        req_held  = is_wr_q ? pmem_write : pmem_read;
        req_other = is_wr_q ? pmem_read  : pmem_write;

        case (state_q)
            IDLE: begin
                if (pmem_read && pmem_write) begin
                    err_d = 1'b1;
                end else if (pmem_read || pmem_write) begin
                    is_wr_d = pmem_write;
                    idx_d   = pmem_address[OFFSET_W +: S_INDEX];
                    cnt_d   = 8'(DELAY);
                    state_d = WAIT;
                end
            end
            WAIT, BURST: begin
                if (!req_held) begin
                    // Abort: staged beats are discarded, the array is never touched.
                    state_d = IDLE;
                    err_d   = 1'b1;
                    stage_d = '0;
                    cnt_d   = '0;
                    beat_d  = '0;
                end else begin
                    if (req_other) begin
                        err_d = 1'b1;
                    end
                    if (state_q == WAIT) begin
                        if (cnt_q <= 8'd1) begin
                            state_d = BURST;
                            cnt_d   = '0;
                            beat_d  = '0;
                            resp_d  = 1'b1;
                            rdata_d = is_wr_q ? '0 : line_beat(rd_line, 2'd0);
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end else begin
                        if (is_wr_q) begin
                            stage_d[beat_q*BEAT_W +: BEAT_W] = pmem_wdata;
                        end
                        if (beat_q == LAST_BEAT) begin
                            // Whole line lands at once, including the final beat.
                            state_d = DONE;
                            beat_d  = '0;
                            stage_d = '0;
                            if (is_wr_q) begin
                                wr_en   = 1'b1;
                                wr_line = {pmem_wdata, stage_q[LINE_W-BEAT_W-1:0]};
                            end
                        end else begin
                            beat_d = beat_q + 2'd1;
                            resp_d = 1'b1;
                            rdata_d = is_wr_q ? '0 : line_beat(rd_line, beat_q + 2'd1);
                        end
                    end
                end
            end
            DONE: begin
                if (!pmem_read && !pmem_write) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            is_wr_q <= 1'b0;
            idx_q   <= '0;
            stage_q <= '0;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            is_wr_q <= is_wr_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign pmem_resp  = resp_q;
    assign pmem_rdata = rdata_q;
    assign pmem_error = err_q;

endmodule
